// File: rtl/mem_access.sv
// Load/store pipeline stage between execute and writeback, with a req/gnt/rvalid data-memory port.
// MEM_MISALIGN_TRAP_EN: when defined, misaligned half/word accesses are flagged instead of issued.
module mem_access #(
  parameter logic [31:0] DMEM_ADDR_MASK = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] r0data_i,
  input  logic [31:0] r1data_i,
  input  logic [31:0] result_i,
  output logic        valid_ro,
  input  logic        ready_i,
  output logic [31:0] pc_ro,
  output logic [31:0] inst_ro,
  output logic [31:0] result_ro,
  output logic        misalign_ro,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      r_state, w_state_next;
  logic        r_valid, r_misalign, r_req, r_we;
  logic [31:0] r_pc, r_inst, r_result, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;

  logic        w_accept, w_consume, w_is_load, w_is_store, w_is_mem;
  logic        w_is_half, w_is_word, w_misalign, w_trap;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm, w_ea, w_ea_access, w_wdata, w_load_data;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_funct3   = inst_i[14:12];
  assign w_is_load  = (inst_i[6:0] == OP_LOAD);
  assign w_is_store = (inst_i[6:0] == OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_imm      = w_is_store ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]}
                                 : {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_ea       = r0data_i + w_imm;

  assign w_is_half  = (w_funct3 == 3'd1) | (w_is_load & (w_funct3 == 3'd5));
  assign w_is_word  = (w_funct3 == 3'd2);
  assign w_misalign = w_is_mem & ((w_is_half & w_ea[0]) | (w_is_word & (|w_ea[1:0])));

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = w_misalign;
`else
  assign w_trap = 1'b0;
`endif

  // Without the trap, misaligned halves/words are forced onto their natural boundary
  always_comb begin
    w_ea_access = w_ea;
    if (w_is_half)      w_ea_access[0]   = 1'b0;
    else if (w_is_word) w_ea_access[1:0] = 2'b00;
  end

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = r1data_i;
    case (w_funct3)
      3'd0: begin
        w_wstrb = 4'b0001 << w_ea[1:0];
        w_wdata = {4{r1data_i[7:0]}};
      end
      3'd1: begin
        w_wstrb = 4'b0011 << {w_ea[1], 1'b0};
        w_wdata = {2{r1data_i[15:0]}};
      end
      3'd2:    w_wstrb = 4'b1111;
      default: w_wstrb = 4'b0000;
    endcase
  end

  // Lane selection uses the raw low address bits captured at accept
  assign w_byte = 8'(dmem_rdata_i >> {r_lane, 3'b000});
  assign w_half = r_lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_load_data = {24'd0, w_byte};
      3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd5:    w_load_data = {16'd0, w_half};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  assign ready_o   = (r_state == IDLE) & (~r_valid | ready_i);
  assign w_accept  = valid_i & ready_o;
  assign w_consume = r_valid & ready_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept & w_is_mem & ~w_trap) w_state_next = REQ;
      REQ:     if (dmem_gnt_i) w_state_next = r_we ? IDLE : WAIT;
      WAIT:    if (dmem_rvalid_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_pc       <= '0;
      r_inst     <= '0;
      r_result   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_funct3   <= '0;
      r_lane     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_consume) r_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_pc   <= pc_i;
          r_inst <= inst_i;
          if (w_is_mem & ~w_trap) begin
            r_req    <= 1'b1;
            r_we     <= w_is_store;
            r_addr   <= w_ea_access & DMEM_ADDR_MASK;
            r_wdata  <= w_wdata;
            r_wstrb  <= w_is_store ? w_wstrb : 4'b0000;
            r_funct3 <= w_funct3;
            r_lane   <= w_ea[1:0];
            r_valid  <= 1'b0;
          end else begin
            r_result   <= w_trap ? w_ea : result_i;
            r_misalign <= w_trap;
            r_valid    <= 1'b1;
          end
        end
        REQ: if (dmem_gnt_i) begin
          r_req <= 1'b0;
          if (r_we) begin
            r_result   <= '0;
            r_misalign <= 1'b0;
            r_valid    <= 1'b1;
          end
        end
        WAIT: if (dmem_rvalid_i) begin
          r_result   <= w_load_data;
          r_misalign <= 1'b0;
          r_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign valid_ro     = r_valid;
  assign pc_ro        = r_pc;
  assign inst_ro      = r_inst;
  assign result_ro    = r_result;
  assign misalign_ro  = r_misalign;
  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign dmem_wstrb_o = r_wstrb;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; inputs driven and outputs sampled 1ns after posedge.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst, valid_i, ready_o, ready_i;
  logic [31:0] pc_i, inst_i, r0data_i, r1data_i, result_i;
  logic        valid_ro, misalign_ro;
  logic [31:0] pc_ro, inst_ro, result_ro;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_wstrb_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW8  = 32'h0080_2083;
  localparam logic [31:0] I_LW2  = 32'h0020_2083;
  localparam logic [31:0] I_SB3  = 32'h0000_01A3;
  localparam logic [31:0] I_LB2  = 32'h0020_0083;
  localparam logic [31:0] I_LBU2 = 32'h0020_4083;
  localparam logic [31:0] I_SW0  = 32'h0000_2023;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .r0data_i(r0data_i), .r1data_i(r1data_i),
    .result_i(result_i), .valid_ro(valid_ro), .ready_i(ready_i),
    .pc_ro(pc_ro), .inst_ro(inst_ro), .result_ro(result_ro),
    .misalign_ro(misalign_ro), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_wstrb_o(dmem_wstrb_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] res);
    pc_i = pc; inst_i = inst; r0data_i = r0; r1data_i = r1; result_i = res;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    $display("txn pc=%h inst=%h r0=%h r1=%h", pc, inst, r0, r1);
  endtask

  task automatic run_load(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] r0, input logic [31:0] rdata);
    issue(pc, inst, r0, 32'd0, 32'd0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    pc_i = '0; inst_i = '0; r0data_i = '0; r1data_i = '0; result_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    tick(); tick();
    chk("rst_valid", {31'd0, valid_ro}, 32'd0);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_result", result_ro, 32'd0);
    chk("rst_misalign", {31'd0, misalign_ro}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    rst = 1'b1;
    tick();

    // ADDI pass-through
    chk("addi_ready_before", {31'd0, ready_o}, 32'd1);
    issue(32'h1000, I_ADDI, 32'd0, 32'd0, 32'h5);
    chk("addi_valid", {31'd0, valid_ro}, 32'd1);
    chk("addi_result", result_ro, 32'h5);
    chk("addi_pc", pc_ro, 32'h1000);
    chk("addi_ready_after", {31'd0, ready_o}, 32'd1);
    tick();
    chk("addi_consumed", {31'd0, valid_ro}, 32'd0);

    // LW at 0x100+8
    issue(32'h1004, I_LW8, 32'h100, 32'd0, 32'd0);
    chk("lw_req", {31'd0, dmem_req_o}, 32'd1);
    chk("lw_addr", dmem_addr_o, 32'h108);
    chk("lw_we", {31'd0, dmem_we_o}, 32'd0);
    chk("lw_ready_req", {31'd0, ready_o}, 32'd0);
    chk("lw_valid_req", {31'd0, valid_ro}, 32'd0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("lw_req_dropped", {31'd0, dmem_req_o}, 32'd0);
    chk("lw_ready_wait", {31'd0, ready_o}, 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_BABE;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("lw_valid", {31'd0, valid_ro}, 32'd1);
    chk("lw_result", result_ro, 32'hCAFE_BABE);
    tick();

    // SB at 0x203
    issue(32'h1008, I_SB3, 32'h200, 32'h0000_00A5, 32'd0);
    chk("sb_we", {31'd0, dmem_we_o}, 32'd1);
    chk("sb_addr", dmem_addr_o, 32'h203);
    chk("sb_wstrb", {28'd0, dmem_wstrb_o}, 32'h8);
    chk("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("sb_valid", {31'd0, valid_ro}, 32'd1);
    chk("sb_result", result_ro, 32'd0);
    chk("sb_req_dropped", {31'd0, dmem_req_o}, 32'd0);
    tick();

    // LB / LBU lane 2
    run_load(32'h100C, I_LB2, 32'h300, 32'h0080_0000);
    chk("lb_result", result_ro, 32'hFFFF_FF80);
    tick();
    run_load(32'h1010, I_LBU2, 32'h300, 32'h0080_0000);
    chk("lbu_result", result_ro, 32'h0000_0080);
    tick();

    // SW with grant withheld, then downstream stall
    ready_i = 1'b0;
    issue(32'h1014, I_SW0, 32'h400, 32'h1234_5678, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sw_hold_req", {31'd0, dmem_req_o}, 32'd1);
      chk("sw_hold_addr", dmem_addr_o, 32'h400);
      chk("sw_hold_wdata", dmem_wdata_o, 32'h1234_5678);
      chk("sw_hold_wstrb", {28'd0, dmem_wstrb_o}, 32'hF);
    end
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("sw_valid", {31'd0, valid_ro}, 32'd1);
    pc_i = 32'h2000; inst_i = I_ADDI; result_i = 32'h77; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, valid_ro}, 32'd1);
      chk("stall_pc", pc_ro, 32'h1014);
      chk("stall_result", result_ro, 32'd0);
      chk("stall_ready", {31'd0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk("stall_released", {31'd0, valid_ro}, 32'd0);

    // Reset while waiting for load data; late rvalid must be ignored
    issue(32'h1018, I_LW8, 32'h100, 32'd0, 32'd0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("rstwait_valid", {31'd0, valid_ro}, 32'd0);
    chk("rstwait_ready", {31'd0, ready_o}, 32'd1);
    chk("rstwait_result", result_ro, 32'd0);
    tick();
    chk("rstwait_valid_later", {31'd0, valid_ro}, 32'd0);

    // Misaligned LW at 0x102
`ifdef MEM_MISALIGN_TRAP_EN
    issue(32'h101C, I_LW2, 32'h100, 32'd0, 32'd0);
    chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
    chk("mis_valid", {31'd0, valid_ro}, 32'd1);
    chk("mis_flag", {31'd0, misalign_ro}, 32'd1);
    chk("mis_result", result_ro, 32'h102);
    issue(32'h1020, I_ADDI, 32'd0, 32'd0, 32'h9);
    chk("mis_flag_clear", {31'd0, misalign_ro}, 32'd0);
    chk("mis_next_result", result_ro, 32'h9);
`else
    issue(32'h101C, I_LW2, 32'h100, 32'd0, 32'd0);
    chk("mis_req", {31'd0, dmem_req_o}, 32'd1);
    chk("mis_addr_aligned", dmem_addr_o, 32'h100);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1122_3344;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("mis_result", result_ro, 32'h1122_3344);
    chk("mis_flag", {31'd0, misalign_ro}, 32'd0);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of execute.
- Consumes execute's registered outputs (pc, inst, r0data, r1data, result) over a valid/ready handshake.
- Performs RV32I loads and stores against a request/grant/response data-memory port and presents the writeback value to the next stage.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- DMEM_ADDR_MASK, 32'hFFFF_FFFF, ANDed onto dmem_addr_o (address window restriction).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- valid_i  input  1  upstream data valid
- ready_o  output  1  stage can accept
- pc_i  input  32  instruction PC
- inst_i  input  32  instruction word
- r0data_i  input  32  rs1 value (base address)
- r1data_i  input  32  rs2 value (store data)
- result_i  input  32  execute result
- valid_ro  output  1  downstream data valid (registered)
- ready_i  input  1  downstream ready
- pc_ro  output  32  registered PC
- inst_ro  output  32  registered instruction
- result_ro  output  32  writeback value
- misalign_ro  output  1  misaligned access flag (see Optional Feature)
- dmem_req_o  output  1  memory request (registered)
- dmem_we_o  output  1  1 = store
- dmem_addr_o  output  32  byte address
- dmem_wdata_o  output  32  store data, lane-replicated
- dmem_wstrb_o  output  4  byte strobes
- dmem_gnt_i  input  1  request accepted
- dmem_rvalid_i  input  1  load data valid
- dmem_rdata_i  input  32  load data word

Behaviour:
- Reset (rst == 0 at clk edge):
  - state = IDLE.
  - valid_ro, dmem_req_o, misalign_ro = 0.
  - All data outputs = 0.
  - Any in-flight transaction is abandoned; a late dmem_rvalid_i is ignored.
- Opcodes: LOAD = 7'b0000011, STORE = 7'b0100011; everything else is pass-through.
- Effective address: ea = r0data_i + sext(imm12).
  - I-type imm inst[31:20] for loads.
  - S-type imm {inst[31:25], inst[11:7]} for stores.
- ready_o = (state == IDLE) & (~valid_ro | ready_i).
- Accept occurs on valid_i & ready_o.
- Output consumed on valid_ro & ready_i; valid_ro drops the next cycle unless a new result is written in the same cycle.
- FSM states: IDLE, REQ, WAIT.
- IDLE, on accept of pass-through:
  - pc_ro/inst_ro/result_ro <= inputs; valid_ro <= 1.
  - Stay in IDLE; latency 1; back-to-back throughput 1/cycle.
- IDLE, on accept of load/store:
  - Latch pc, inst, ea, funct3, data.
  - dmem_req_o <= 1 and drive dmem_* from registers; valid_ro <= 0; go to REQ.
- REQ:
  - dmem_* held stable until dmem_gnt_i.
  - On grant of a store: dmem_req_o <= 0, valid_ro <= 1, result_ro <= 0, go to IDLE.
  - On grant of a load: dmem_req_o <= 0, go to WAIT.
  - dmem_rvalid_i is ignored in REQ.
- WAIT:
  - On dmem_rvalid_i: result_ro <= extracted data, valid_ro <= 1, go to IDLE.
  - Unbounded wait.
- Load extraction (lane = ea[1:0]):
  - LB: sext of byte lane. LBU: zext of byte lane.
  - LH: sext of half ea[1]. LHU: zext of half ea[1].
  - LW and funct3 3/6/7: full word.
- Store strobes:
  - SB: 4'b0001 << ea[1:0]. SH: 4'b0011 << {ea[1], 1'b0}. SW: 4'b1111.
  - Store funct3 >= 3: strobe 4'b0000, transaction still issued.
- dmem_wdata_o replication:
  - SB: byte replicated ×4.
  - SH: half replicated ×2.
  - SW: word as-is.
- dmem_addr_o = ea & DMEM_ADDR_MASK.
- Minimum load latency: accept at cycle N, req at N+1, gnt at N+1, rvalid at N+2, valid_ro at N+3.
- Minimum store latency: accept at N, gnt at N+1, valid_ro at N+2.
- While valid_ro is held by ready_i = 0: outputs are stable and no accept occurs.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned cases are LH/LHU/SH with ea[0] = 1, and LW/SW with ea[1:0] != 0.
  - No memory request is issued; the stage completes like a pass-through (valid_ro next cycle).
  - misalign_ro = 1 and result_ro = ea.
  - misalign_ro clears on the next result written.
- Undefined:
  - Misaligned low address bits are cleared before access (half: ea[0] = 0; word: ea[1:0] = 0).
  - misalign_ro is tied 0.

Test Plan:
- ADDI pass-through, result_i = 32'h5, ready_i = 1 -> valid_ro = 1 one cycle after accept, result_ro = 32'h5, ready_o stays 1.
- LW, r0data = 32'h100, imm = 8, gnt immediate, rvalid next cycle with rdata = 32'hCAFEBABE -> dmem_addr_o = 32'h108, dmem_we_o = 0, result_ro = 32'hCAFEBABE at accept+3, ready_o = 0 during REQ/WAIT.
- SB, ea = 32'h203, r1data = 32'h000000A5 -> wstrb = 4'b1000, wdata = 32'hA5A5A5A5, result_ro = 0.
- LB, ea[1:0] = 2, rdata = 32'h0080_0000 -> result_ro = 32'hFFFFFF80. LBU with the same stimulus -> result_ro = 32'h00000080.
- Grant held low for 5 cycles with ready_i = 0 at completion -> dmem_* stable for 5 cycles; valid_ro held with result stable until ready_i = 1.
- Reset asserted in WAIT, then rvalid pulse -> valid_ro stays 0 and state is IDLE. Separately, with MEM_MISALIGN_TRAP_EN defined, LW at ea = 32'h102 -> no dmem_req_o, misalign_ro = 1, result_ro = 32'h102.
